// File: rtl/snake_pkg.sv
// snake_pkg: screen geometry, pixel widths and plot arbiter state encoding
// shared by the snake game blocks.
package snake_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    localparam int SCREEN_X_MAX = 159;
    localparam int SCREEN_Y_MAX = 119;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_A = 2'd1;
    localparam logic [1:0] ST_GNT_B = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    // Owner choice at a burst boundary: a pending clear wins,
    // then a lone requester, then the round-robin favourite.
    function automatic logic [1:0] next_from_idle(
        input logic pend,
        input logic a_req,
        input logic b_req,
        input logic fav_b
    );
        logic [1:0] nxt;
        if (pend) begin
            nxt = ST_CLEAR;
        end else begin
            unique case ({a_req, b_req})
                2'b11:   nxt = fav_b ? ST_GNT_B : ST_GNT_A;
                2'b10:   nxt = ST_GNT_A;
                2'b01:   nxt = ST_GNT_B;
                default: nxt = ST_IDLE;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if: one pixel requester's link to the plot arbiter;
// a pixel moves on any cycle where req and gnt are both high.
interface vga_plot_arbiter_if #(
    parameter int X_W = snake_pkg::X_W,
    parameter int Y_W = snake_pkg::Y_W,
    parameter int C_W = snake_pkg::C_W
);
    logic           req;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] col;
    logic           last;
    logic           gnt;

    modport master (output req, x, y, col, last, input gnt);
    modport slave  (input req, x, y, col, last, output gnt);
endinterface

// File: rtl/vga_clear_sweeper.sv
// vga_clear_sweeper: walks every screen pixel in raster order, one per
// cycle, after a start pulse, presenting a fixed fill colour.
module vga_clear_sweeper #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [C_W-1:0] colour,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [C_W-1:0] fill_colour,
    output logic           valid,
    output logic           last
);
    logic active;
    logic x_end;
    logic y_end;

    assign x_end = (x == X_W'(X_MAX));
    assign y_end = (y == Y_W'(Y_MAX));
    assign valid = active;
    assign last  = active && x_end && y_end;

    // Nested raster counters; x wraps into the next row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            fill_colour <= '0;
        end else if (start) begin
            active      <= 1'b1;
            x           <= '0;
            y           <= '0;
            fill_colour <= colour;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
            end
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the framebuffer write port between the snake
// and food drawers, with a built-in full-screen clear sequencer.
module vga_plot_arbiter #(
    parameter int X_W            = snake_pkg::X_W,
    parameter int Y_W            = snake_pkg::Y_W,
    parameter int C_W            = snake_pkg::C_W,
    parameter int X_MAX          = snake_pkg::SCREEN_X_MAX,
    parameter int Y_MAX          = snake_pkg::SCREEN_Y_MAX,
    parameter int MAX_BURST      = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    vga_plot_arbiter_if.slave        a,
    vga_plot_arbiter_if.slave        b,
    input  logic                     clear_start,
    input  logic [C_W-1:0]           clear_colour,
    output logic                     clear_busy,
    output logic                     clear_done,
    output logic [X_W-1:0]           x_out,
    output logic [Y_W-1:0]           y_out,
    output logic [C_W-1:0]           colour_out,
    output logic                     plot
);
    import snake_pkg::*;

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             rr_b;
    logic             clear_pend;
    logic [CNT_W-1:0] burst_cnt;
    logic             a_xfer;
    logic             b_xfer;
    logic             cur_req;
    logic             cur_last;
    logic             burst_end;
    logic             sw_start;
    logic [X_W-1:0]   sw_x;
    logic [Y_W-1:0]   sw_y;
    logic [C_W-1:0]   sw_col;
    logic             sw_valid;
    logic             sw_last;

    assign a.gnt      = (state == ST_GNT_A);
    assign b.gnt      = (state == ST_GNT_B);
    assign clear_busy = (state == ST_CLEAR);
    assign a_xfer     = (state == ST_GNT_A) && a.req;
    assign b_xfer     = (state == ST_GNT_B) && b.req;
    assign cur_req    = (state == ST_GNT_A) ? a.req  : b.req;
    assign cur_last   = (state == ST_GNT_A) ? a.last : b.last;

    vga_clear_sweeper #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .C_W   (C_W),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_sweep (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (sw_start),
        .colour      (clear_colour),
        .x           (sw_x),
        .y           (sw_y),
        .fill_colour (sw_col),
        .valid       (sw_valid),
        .last        (sw_last)
    );

    // Next owner; a burst end re-decides in the same cycle so no bubble.
    always_comb begin
        state_nxt = state;
        burst_end = 1'b0;
        unique case (state)
            ST_IDLE: begin
                state_nxt = next_from_idle(clear_pend, a.req, b.req, rr_b);
            end
            ST_GNT_A, ST_GNT_B: begin
                burst_end = !cur_req || cur_last ||
                            (burst_cnt == CNT_W'(MAX_BURST - 1));
                if (burst_end) begin
                    state_nxt = next_from_idle(clear_pend, a.req, b.req,
                                               state == ST_GNT_A);
                end
            end
            ST_CLEAR: begin
                if (sw_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        sw_start = (state != ST_CLEAR) && (state_nxt == ST_CLEAR);
    end

    // State, round-robin pointer, pending clear and burst length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            rr_b       <= 1'b0;
            clear_pend <= CLEAR_ON_RESET;
            burst_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (burst_end) begin
                rr_b <= (state == ST_GNT_A);
            end
            if (sw_start) begin
                clear_pend <= 1'b0;
            end else if (clear_start && state != ST_CLEAR) begin
                clear_pend <= 1'b1;
            end
            if (burst_end || state == ST_IDLE) begin
                burst_cnt <= '0;
            end else if (a_xfer || b_xfer) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

    // Framebuffer write register: one cycle behind the transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            plot       <= 1'b0;
            clear_done <= 1'b0;
            unique case (1'b1)
                a_xfer: begin
                    x_out      <= a.x;
                    y_out      <= a.y;
                    colour_out <= a.col;
                    plot       <= 1'b1;
                end
                b_xfer: begin
                    x_out      <= b.x;
                    y_out      <= b.y;
                    colour_out <= b.col;
                    plot       <= 1'b1;
                end
                (clear_busy && sw_valid): begin
                    x_out      <= sw_x;
                    y_out      <= sw_y;
                    colour_out <= sw_col;
                    plot       <= 1'b1;
                    clear_done <= sw_last;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: scoreboard bench; a port-ownership model predicts
// each cycle's plot, a negedge monitor compares the DUT against it.
module tb_vga_plot_arbiter;
    import snake_pkg::*;

    localparam int MB   = 4;
    localparam int XM   = SCREEN_X_MAX;
    localparam int YM   = SCREEN_Y_MAX;
    localparam int NPIX = (XM + 1) * (YM + 1);

    typedef struct packed {
        logic           plot;
        logic           done;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           clear_start = 1'b0;
    logic [C_W-1:0] clear_colour = '0;
    logic           clear_busy;
    logic           clear_done;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [C_W-1:0] colour_out;
    logic           plot;

    vga_plot_arbiter_if a_if ();
    vga_plot_arbiter_if b_if ();

    vga_plot_arbiter #(.MAX_BURST(MB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .a            (a_if),
        .b            (b_if),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .x_out        (x_out),
        .y_out        (y_out),
        .colour_out   (colour_out),
        .plot         (plot)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Owner: 0 none, 1 snake, 2 food, 3 clear.
    function automatic int choose(bit pend, bit ar, bit br, int fav);
        if (pend) return 3;
        if (ar && br) return (fav == 0) ? 1 : 2;
        if (ar) return 1;
        if (br) return 2;
        return 0;
    endfunction

    exp_t           sb[$];
    int             m_own;
    int             m_fav;
    bit             m_pend;
    int             m_n;
    int             m_k;
    logic [C_W-1:0] m_col;
    bit             e_ga;
    bit             e_gb;
    bit             e_busy;

    // Reference model: who owns the port, and what it writes next cycle.
    always @(posedge clk or negedge reset_n) begin
        exp_t e;
        bit   rq;
        bit   lst;
        bit   setp;
        int   nxt;
        if (!reset_n) begin
            sb.delete();
            m_own  = 0;
            m_fav  = 0;
            m_pend = 1'b1;
            m_n    = 0;
            m_k    = 0;
            e_ga   = 1'b0;
            e_gb   = 1'b0;
            e_busy = 1'b0;
        end else begin
            e    = '0;
            setp = clear_start && (m_own != 3);
            nxt  = m_own;
            if (m_own == 0) begin
                nxt = choose(m_pend, a_if.req, b_if.req, m_fav);
                m_n = 0;
            end else if (m_own == 3) begin
                e.plot = 1'b1;
                e.x    = X_W'(m_k % (XM + 1));
                e.y    = Y_W'(m_k / (XM + 1));
                e.c    = m_col;
                m_k++;
                if (m_k == NPIX) begin
                    e.done = 1'b1;
                    nxt    = 0;
                end
            end else begin
                rq  = (m_own == 1) ? a_if.req  : b_if.req;
                lst = (m_own == 1) ? a_if.last : b_if.last;
                if (rq) begin
                    e.plot = 1'b1;
                    e.x    = (m_own == 1) ? a_if.x   : b_if.x;
                    e.y    = (m_own == 1) ? a_if.y   : b_if.y;
                    e.c    = (m_own == 1) ? a_if.col : b_if.col;
                    m_n++;
                end
                if (!rq || lst || m_n == MB) begin
                    m_fav = (m_own == 1) ? 1 : 0;
                    nxt   = choose(m_pend, a_if.req, b_if.req, m_fav);
                    m_n   = 0;
                end
            end
            if (nxt == 3 && m_own != 3) begin
                m_pend = 1'b0;
                m_k    = 0;
                m_col  = clear_colour;
            end else if (setp) begin
                m_pend = 1'b1;
            end
            sb.push_back(e);
            m_own  = nxt;
            e_ga   = (nxt == 1);
            e_gb   = (nxt == 2);
            e_busy = (nxt == 3);
        end
    end

    // Monitor: compare DUT outputs against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            check("rst_plot", 32'(plot), 32'd0);
            check("rst_busy", 32'(clear_busy), 32'd0);
            check("rst_gnt", 32'({a_if.gnt, b_if.gnt}), 32'd0);
        end else begin
            e = '0;
            if (sb.size() != 0) e = sb.pop_front();
            check("a_gnt", 32'(a_if.gnt), 32'(e_ga));
            check("b_gnt", 32'(b_if.gnt), 32'(e_gb));
            check("busy", 32'(clear_busy), 32'(e_busy));
            check("plot", 32'(plot), 32'(e.plot));
            check("done", 32'(clear_done), 32'(e.done));
            if (e.plot) begin
                check("x", 32'(x_out), 32'(e.x));
                check("y", 32'(y_out), 32'(e.y));
                check("col", 32'(colour_out), 32'(e.c));
            end
        end
    end

    bit rnd = 1'b0;
    bit a_on = 1'b0;
    bit b_on = 1'b0;
    int a_len = 0;
    int b_len = 0;
    int a_lim = 0;
    int a_cnt = 0;
    int b_cnt = 0;
    bit a_fire;
    bit b_fire;

    task automatic step();
        @(negedge clk);
        a_fire = a_if.req && a_if.gnt;
        b_fire = b_if.req && b_if.gnt;
        @(posedge clk);
        #1;
        if (a_fire) begin
            a_cnt++;
            a_if.x   = X_W'($urandom);
            a_if.y   = Y_W'($urandom);
            a_if.col = C_W'($urandom);
        end
        if (b_fire) begin
            b_cnt++;
            b_if.x   = X_W'($urandom);
            b_if.y   = Y_W'($urandom);
            b_if.col = C_W'($urandom);
        end
        if (rnd) begin
            a_if.req  = 1'($urandom);
            a_if.last = 1'($urandom);
            a_if.x    = X_W'($urandom);
            b_if.req  = 1'($urandom);
            b_if.last = 1'($urandom);
            b_if.y    = Y_W'($urandom);
        end else begin
            if (a_lim != 0 && a_cnt >= a_lim) a_on = 1'b0;
            a_if.req  = a_on;
            a_if.last = (a_len != 0) && (a_cnt % a_len == a_len - 1);
            b_if.req  = b_on;
            b_if.last = (b_len != 0) && (b_cnt % b_len == b_len - 1);
        end
    endtask

    initial begin
        a_if.req = 1'b0; a_if.last = 1'b0;
        a_if.x = '0; a_if.y = '0; a_if.col = 3'd1;
        b_if.req = 1'b0; b_if.last = 1'b0;
        b_if.x = 8'd7; b_if.y = 7'd9; b_if.col = 3'd6;
        clear_colour = 3'd4;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Power-up clear, cut short by a reset around pixel 500.
        repeat (500) step();
        reset_n = 1'b0;
        #1;
        check("async_plot", 32'(plot), 32'd0);
        check("async_busy", 32'(clear_busy), 32'd0);
        check("async_gnt", 32'({a_if.gnt, b_if.gnt}), 32'd0);
        repeat (2) step();
        clear_colour = 3'd3;
        reset_n = 1'b1;
        repeat (NPIX + 10) step();

        // Both requesters streaming without last: A4, B4, A4...
        a_on = 1'b1;
        b_on = 1'b1;
        repeat (40) step();
        a_on = 1'b0;
        b_on = 1'b0;
        repeat (4) step();

        // Lone three-pixel burst from A.
        a_cnt = 0;
        a_len = 3;
        a_lim = 3;
        a_on  = 1'b1;
        repeat (10) step();
        a_lim = 0;

        // Clear requested mid-burst, then again while clearing.
        a_cnt = 0;
        a_len = 8;
        a_on  = 1'b1;
        b_on  = 1'b1;
        repeat (2) step();
        clear_colour = 3'd5;
        clear_start  = 1'b1;
        step();
        clear_start  = 1'b0;
        repeat (1000) step();
        clear_colour = 3'd2;
        clear_start  = 1'b1;
        step();
        clear_start  = 1'b0;
        repeat (NPIX) step();

        // Random requester traffic.
        rnd = 1'b1;
        repeat (3000) step();
        rnd  = 1'b0;
        a_on = 1'b0;
        b_on = 1'b0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
